// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, WIDTH data bits LSB-first,
// stop bit, each bit held for DIV clocks; done pulses once the frame has ended.
module serial_tx #(
  parameter int WIDTH = 4,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic             ready,
  output logic             busy,
  output logic             tx,
  output logic             done
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               tx_q, tx_d;
  logic               done_q, done_d;
  logic               div_end;

  // Handshake: a word is taken on any rising edge where en && ready; ready is
  // the registered IDLE state, so en is never queued while a frame is running.
  assign div_end = (div_q == DIV_W'(DIV - 1));

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    div_d   = div_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (en) begin
          shift_d = d;
          bit_d   = '0;
          div_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (div_end) begin
          div_d   = '0;
          state_d = S_DATA;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DATA: begin
        if (div_end) begin
          div_d   = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(WIDTH - 1)) begin
            state_d = S_STOP;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_STOP: begin
        if (div_end) begin
          div_d   = '0;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is decoded from the next state so tx comes straight off a flop.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign ready = (state_q == S_IDLE);
  assign tx    = tx_q;
  assign done  = done_q;

endmodule
